// File: rtl/memory_sequencer_if.sv
// Instruction-stream signals between controller/memory and memory_sequencer.
// master = environment (controller and memory), slave = the sequencer.
interface memory_sequencer_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 32
);
  logic [0:INSTRUCTION_WIDTH-1] instr_in;
  logic                         instr_valid_in;
  logic                         instr_ready_out;
  logic                         write_buffer_valid_in;
  logic                         abc_valid_in;
  logic [0:INSTRUCTION_WIDTH-1] mem_instr_out;
  logic                         mem_instr_valid_out;
  logic                         write_buffer_ack_out;
  logic                         busy_out;
  logic                         halted_out;
  logic                         error_out;
  logic [15:0]                  issued_count_out;

  modport master (
    output instr_in, instr_valid_in, write_buffer_valid_in, abc_valid_in,
    input  instr_ready_out, mem_instr_out, mem_instr_valid_out, write_buffer_ack_out,
           busy_out, halted_out, error_out, issued_count_out
  );

  modport slave (
    input  instr_in, instr_valid_in, write_buffer_valid_in, abc_valid_in,
    output instr_ready_out, mem_instr_out, mem_instr_valid_out, write_buffer_ack_out,
           busy_out, halted_out, error_out, issued_count_out
  );
endinterface

// File: rtl/memory_sequencer.sv
// Buffers controller instructions and issues them to memory in order, inserting
// the WRITEB, SENDL and LOADB stalls memory needs.
module memory_sequencer #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned WB_TIMEOUT        = 15
) (
  input logic               clk_in,
  input logic               rst_in,
  memory_sequencer_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TMR_W = $clog2(WB_TIMEOUT + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;
  typedef logic [TMR_W-1:0] tmr_t;

  localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);
  localparam tmr_t TMR_LAST = tmr_t'(WB_TIMEOUT - 1);

  localparam logic [3:0] OP_END    = 4'b0001;
  localparam logic [3:0] OP_SENDL  = 4'b1000;
  localparam logic [3:0] OP_LOADB  = 4'b1001;
  localparam logic [3:0] OP_WRITEB = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_WAIT,
    ST_SENDL_GAP,
    ST_BUF_WAIT,
    ST_HALT
  } state_t;

  state_t state, state_next;

  logic [0:INSTRUCTION_WIDTH-1] fifo_mem [FIFO_DEPTH];
  ptr_t                         wr_ptr, rd_ptr;
  cnt_t                         count;
  logic [0:INSTRUCTION_WIDTH-1] head;
  logic [3:0]                   head_op;
  logic                         fifo_empty, push, pop, issue, ack, wb_expire;
  tmr_t                         wb_timer;

  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign head_op    = head[0:3];

  assign bus.instr_ready_out = !rst_in && (count != CNT_FULL) && !bus.halted_out;
  assign bus.busy_out        = !fifo_empty || (state != ST_IDLE);
  assign push                = bus.instr_valid_in && bus.instr_ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_END:    state_next = ST_HALT;
            OP_LOADB:  if (bus.write_buffer_valid_in) state_next = ST_BUF_WAIT;
            OP_WRITEB: state_next = ST_WB_WAIT;
            OP_SENDL:  state_next = ST_SENDL_GAP;
            default:   state_next = ST_IDLE;
          endcase
        end
      end
      ST_WB_WAIT:   if (bus.abc_valid_in || wb_expire) state_next = ST_IDLE;
      ST_SENDL_GAP: state_next = ST_IDLE;
      ST_BUF_WAIT:  state_next = ST_IDLE;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_IDLE;
    endcase
  end

  // LOADB is held at the head until BUF_WAIT, giving memory a cycle to latch the line.
  always_comb begin
    issue     = 1'b0;
    pop       = 1'b0;
    ack       = 1'b0;
    wb_expire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_END:   pop = 1'b1;
            OP_LOADB: ;
            default: begin
              issue = 1'b1;
              pop   = 1'b1;
            end
          endcase
        end
      end
      ST_BUF_WAIT: begin
        issue = 1'b1;
        pop   = 1'b1;
        ack   = 1'b1;
      end
      ST_WB_WAIT: wb_expire = !bus.abc_valid_in && (wb_timer == TMR_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr                   <= '0;
      rd_ptr                   <= '0;
      count                    <= '0;
      wb_timer                 <= '0;
      bus.mem_instr_out        <= '0;
      bus.mem_instr_valid_out  <= 1'b0;
      bus.write_buffer_ack_out <= 1'b0;
      bus.halted_out           <= 1'b0;
      bus.error_out            <= 1'b0;
      bus.issued_count_out     <= '0;
    end else begin
      bus.mem_instr_valid_out  <= issue;
      bus.write_buffer_ack_out <= ack;
      if (issue) begin
        bus.mem_instr_out    <= head;
        bus.issued_count_out <= bus.issued_count_out + 16'd1;
      end
      if (wb_expire) bus.error_out <= 1'b1;
      if (state_next == ST_HALT) bus.halted_out <= 1'b1;
      wb_timer <= (state == ST_WB_WAIT) ? wb_timer + 1'b1 : '0;

      if (state == ST_HALT) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= bus.instr_in;
  end
endmodule

// File: doc/memory_sequencer.md
# memory_sequencer

Issues the controller's instruction stream to the `memory` block. It buffers instructions in a small FIFO and inserts the stalls `memory` needs: it waits for the WRITEB read to return, leaves a gap after SENDL, and gates LOADB on FMA write-buffer data. It sits between the instruction controller and `memory`, and drives `memory`'s `instr_in`/`instr_valid_in` directly.

## Interface
- `INSTRUCTION_WIDTH`, 32, instruction width; bit 0 is MSB, opcode in `[0:3]`.
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2.
- `WB_TIMEOUT`, 15, max cycles to wait for `abc_valid_in` after a WRITEB issue.
- `clk_in`  input  1  clock.
- `rst_in`  input  1  reset; synchronous, active-high.
- `instr_in`  input  [0:INSTRUCTION_WIDTH-1]  instruction from controller.
- `instr_valid_in`  input  1  `instr_in` valid.
- `instr_ready_out`  output  1  FIFO can accept; transfer when valid & ready.
- `write_buffer_valid_in`  input  1  FMA write buffer holds a line.
- `abc_valid_in`  input  1  `memory`'s `abc_valid_out`.
- `mem_instr_out`  output  [0:INSTRUCTION_WIDTH-1]  to `memory.instr_in`.
- `mem_instr_valid_out`  output  1  to `memory.instr_valid_in`; one-cycle pulse per issue.
- `write_buffer_ack_out`  output  1  pulse when a LOADB issues; buffer may advance.
- `busy_out`  output  1  FIFO non-empty or state ≠ IDLE.
- `halted_out`  output  1  OP_END consumed.
- `error_out`  output  1  sticky; WRITEB timeout.
- `issued_count_out`  output  16  instructions issued to `memory`; wraps at 2^16.

## Operation
- The FIFO is registered. `instr_ready_out` = `!rst_in && count<FIFO_DEPTH && !halted_out`. There is no bypass path, and a push while full is impossible by construction.
- Opcodes: NOP 0000, END 0001, SMA 0110, LOADI 0111, SENDL 1000, LOADB 1001, WRITEB 1010, LOAD 1101. All others are forwarded unchanged.
- FSM states are IDLE, WB_WAIT, SENDL_GAP, BUF_WAIT and HALT.
- **IDLE** with FIFO non-empty examines the head:
  - **END:** pop; do not forward; go to HALT.
  - **LOADB:** if `write_buffer_valid_in`=1 this cycle, go to BUF_WAIT (no pop yet). Otherwise stay in IDLE.
  - **WRITEB:** issue and pop; clear the timer; go to WB_WAIT.
  - **SENDL:** issue and pop; go to SENDL_GAP.
  - **Any other opcode:** issue and pop; stay in IDLE.
- **BUF_WAIT:** issue the LOADB, pop it, and pulse `write_buffer_ack_out`; return to IDLE. This one-cycle delay lets `memory` latch the buffer line before LOADB executes.
- **WB_WAIT:**
  - No issue.
  - The timer increments each cycle.
  - On `abc_valid_in`=1, return to IDLE.
  - If the timer reaches `WB_TIMEOUT` first, set `error_out` and return to IDLE.
- **SENDL_GAP:** exactly one idle cycle, then IDLE.
- **HALT:**
  - Terminal until reset.
  - Remaining FIFO entries are discarded, so the FIFO count becomes 0.
  - No issues; `instr_ready_out`=0.
- Issue means: `mem_instr_out` ← head, `mem_instr_valid_out` ← 1 for one cycle, and `issued_count_out` += 1.
- `abc_valid_in` outside WB_WAIT is ignored.
- A push and a pop in the same cycle is legal; count is unchanged.
- Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset:
  - All outputs are 0, `mem_instr_out`=0, FIFO empty, state IDLE, timer 0.
  - `instr_ready_out`=0 while `rst_in` is high, and 1 the first cycle after.
- Reset mid-operation, in any state, returns to IDLE the next cycle. An in-flight WRITEB wait is abandoned and FIFO contents are lost.
- All outputs are registered except `instr_ready_out` and `busy_out`.
- Latency for a plain instruction: accepted at edge t, `mem_instr_valid_out` high during cycle t+1.
- Back-to-back plain instructions issue at one per cycle.
- WRITEB issued in cycle i: the next issue happens no earlier than the cycle after `abc_valid_in` is observed. With `memory` as built, that is i+5.
- SENDL issued in cycle i: the next issue happens no earlier than i+2.
- LOADB at the head:
  - If `write_buffer_valid_in` is high in cycle j, the issue and ack occur in cycle j+1.
  - If `write_buffer_valid_in` is low, the LOADB waits indefinitely and later instructions block behind it (in-order issue).
- END at the head in cycle k: `halted_out`=1 from cycle k+1.

## Test plan
- **Reset, then plain stream:** push SMA(5), LOADI, LOADI on consecutive cycles → `mem_instr_valid_out` high for 3 consecutive cycles starting 1 cycle after the first push; `issued_count_out`=3.
- **WRITEB stall:** push WRITEB then SMA; model `abc_valid_in` 4 cycles after the WRITEB issue → SMA issues exactly 1 cycle after `abc_valid_in`, never earlier.
- **WRITEB timeout:** push WRITEB with `abc_valid_in` held at 0 → `error_out`=1 after 15 wait cycles, then the FSM returns to IDLE and the next instruction issues.
- **SENDL gap:** push SENDL and NOP back-to-back → issues 2 cycles apart.
- **LOADB gating:** LOADB at the head with `write_buffer_valid_in`=0 for 6 cycles, then 1 → no issue during the 6 cycles; issue and `write_buffer_ack_out` 1 cycle after the rise.
- **Full, END and reset:**
  - Fill the FIFO with 4 entries while the head is stalled → `instr_ready_out`=0 and a fifth push is not accepted.
  - Push END then NOP → NOP is not issued; `halted_out`=1; ready stays 0.
  - Assert `rst_in` → all outputs return to 0, and ready goes to 1 the cycle after reset deasserts.
